implication_sweeper: RTL and testbench

Parametrised self-checking sweeper for the two-input gate family. One clock, one vector per accepted cycle over all 2^(2·WIDTH) combinations of WIDTH-bit operands x and y. Each vector is evaluated by two paths, a NAND-only structural path (res_a) and a behavioural expression path (res_b). The block counts mismatches, records the first failing index, and reports pass/fail at the end of the sweep. It is the clocked successor of the single-bit NAND-built implication gate and its hand-driven truth-table bench.

---
 rtl/implication_sweeper_if.sv | 37 +++
 rtl/implication_sweeper.sv | 168 ++++++++++++++++
 tb/tb_implication_sweeper.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/implication_sweeper_if.sv
// Control, configuration and vector/result bundle between the sweeper and
// whatever drives it; master is the controller/consumer side.
interface implication_sweeper_if #(
    parameter int WIDTH = 2
);
    localparam int IDX_W = 2 * WIDTH;

    logic             start;
    logic             abort;
    logic [1:0]       op;
    logic             fault_en;
    logic [IDX_W-1:0] fault_idx;
    logic             vec_ready;

    logic             vec_valid;
    logic [WIDTH-1:0] vec_x;
    logic [WIDTH-1:0] vec_y;
    logic [WIDTH-1:0] res_a;
    logic [WIDTH-1:0] res_b;
    logic [IDX_W:0]   mismatch_cnt;
    logic             first_fail_valid;
    logic [IDX_W-1:0] first_fail_idx;
    logic             done;
    logic             pass;

    modport master (
        output start, abort, op, fault_en, fault_idx, vec_ready,
        input  vec_valid, vec_x, vec_y, res_a, res_b, mismatch_cnt,
               first_fail_valid, first_fail_idx, done, pass
    );

    modport slave (
        input  start, abort, op, fault_en, fault_idx, vec_ready,
        output vec_valid, vec_x, vec_y, res_a, res_b, mismatch_cnt,
               first_fail_valid, first_fail_idx, done, pass
    );
endinterface

// File: rtl/implication_sweeper.sv
// Exhaustive two-input gate sweeper: a NAND-only netlist is compared against a
// behavioural expression for every (x, y) operand pair of the selected gate.
module implication_sweeper #(
    parameter int WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    implication_sweeper_if.slave bus
);
    localparam int IDX_W = 2 * WIDTH;

    // state  | meaning
    // IDLE   | waiting for start, vec_valid low
    // RUN    | presenting vectors, counting mismatches on each accept
    // DONE   | one-cycle done pulse, pass valid, then back to IDLE
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       op_q, op_d;
    logic             fault_en_q, fault_en_d;
    logic [IDX_W-1:0] fault_idx_q, fault_idx_d;
    logic [IDX_W:0]   cnt_q, cnt_d;
    logic             ffv_q, ffv_d;
    logic [IDX_W-1:0] ffi_q, ffi_d;
    logic             pass_q, pass_d;

    wire  [WIDTH-1:0] x = idx_q[IDX_W-1:WIDTH];
    wire  [WIDTH-1:0] y = idx_q[WIDTH-1:0];
    wire  [WIDTH-1:0] res_s;
    wire              nop0, nop1;
    logic [WIDTH-1:0] res_a_v, res_b_v;
    logic             fault_hit, mis, run, last;

    nand u_nop0 (nop0, op_q[0], op_q[0]);
    nand u_nop1 (nop1, op_q[1], op_q[1]);

    // Per bit: four gate candidates, then a NAND-built 4:1 mux keyed by op_q.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        wire nx, ny, imp, cnv, nd, or_v, nr, m0a, m0b, m0, m1a, m1b, m1, oa, ob;
        nand u_nx  (nx,  x[i], x[i]);
        nand u_ny  (ny,  y[i], y[i]);
        nand u_imp (imp, x[i], ny);
        nand u_cnv (cnv, nx, y[i]);
        nand u_nd  (nd,  x[i], y[i]);
        nand u_or  (or_v, nx, ny);
        nand u_nr  (nr,  or_v, or_v);
        nand u_m0a (m0a, imp, nop0);
        nand u_m0b (m0b, cnv, op_q[0]);
        nand u_m0  (m0,  m0a, m0b);
        nand u_m1a (m1a, nd, nop0);
        nand u_m1b (m1b, nr, op_q[0]);
        nand u_m1  (m1,  m1a, m1b);
        nand u_oa  (oa,  m0, nop1);
        nand u_ob  (ob,  m1, op_q[1]);
        nand u_o   (res_s[i], oa, ob);
    end

    always_comb begin
        res_b_v = '0;
        case (op_q)
            2'd0:    res_b_v = ~x | y;
            2'd1:    res_b_v = x | ~y;
            2'd2:    res_b_v = ~(x & y);
            default: res_b_v = ~(x | y);
        endcase
    end

    assign fault_hit = fault_en_q && (idx_q == fault_idx_q);

    always_comb begin
        res_a_v    = res_s;
        res_a_v[0] = res_s[0] ^ fault_hit;
    end

    assign mis  = (res_a_v != res_b_v);
    assign run  = (state_q == S_RUN);
    assign last = (idx_q == {IDX_W{1'b1}});

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        op_d        = op_q;
        fault_en_d  = fault_en_q;
        fault_idx_d = fault_idx_q;
        cnt_d       = cnt_q;
        ffv_d       = ffv_q;
        ffi_d       = ffi_q;
        pass_d      = pass_q;
        if (bus.abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        op_d        = bus.op;
                        fault_en_d  = bus.fault_en;
                        fault_idx_d = bus.fault_idx;
                        idx_d       = '0;
                        cnt_d       = '0;
                        ffv_d       = 1'b0;
                        ffi_d       = '0;
                        pass_d      = 1'b0;
                        state_d     = S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.vec_ready) begin
                        if (mis) begin
                            cnt_d = cnt_q + (IDX_W+1)'(1);
                            if (!ffv_q) begin
                                ffv_d = 1'b1;
                                ffi_d = idx_q;
                            end
                        end
                        if (last) begin
                            state_d = S_DONE;
                            pass_d  = (cnt_d == '0);
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            op_q        <= '0;
            fault_en_q  <= 1'b0;
            fault_idx_q <= '0;
            cnt_q       <= '0;
            ffv_q       <= 1'b0;
            ffi_q       <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            fault_en_q  <= fault_en_d;
            fault_idx_q <= fault_idx_d;
            cnt_q       <= cnt_d;
            ffv_q       <= ffv_d;
            ffi_q       <= ffi_d;
            pass_q      <= pass_d;
        end
    end

    assign bus.vec_valid        = run;
    assign bus.vec_x            = run ? x : '0;
    assign bus.vec_y            = run ? y : '0;
    assign bus.res_a            = run ? res_a_v : '0;
    assign bus.res_b            = run ? res_b_v : '0;
    assign bus.mismatch_cnt     = cnt_q;
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_idx   = ffi_q;
    assign bus.done             = (state_q == S_DONE);
    assign bus.pass             = pass_q;
endmodule

// File: tb/tb_implication_sweeper.sv
// Bench for implication_sweeper: table of probe vectors, random sweeps against
// an arithmetic gate model, and hand sequences for abort, reset and WIDTH=3.
module tb_implication_sweeper;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    implication_sweeper_if #(.WIDTH(2)) b2 ();
    implication_sweeper_if #(.WIDTH(3)) b3 ();

    implication_sweeper #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    implication_sweeper #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] op;
        bit         fen;
        logic [3:0] fidx;
        int         x;
        int         y;
        int         a;
        int         b;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_gate(input logic [1:0] op, input int x, input int y, input int w);
        int m;
        int r;
        m = (1 << w) - 1;
        case (op)
            2'd0:    r = ~x | y;
            2'd1:    r = x | ~y;
            2'd2:    r = ~(x & y);
            default: r = ~(x | y);
        endcase
        return r & m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // rmode: 0 always ready, 1 pattern 1,0,0,1, 2 random ready.
    // jitter scrambles op/fault/start while the sweep runs; the DUT must ignore it.
    task automatic sweep2(input logic [1:0] op, input bit fen, input logic [3:0] fidx,
                          input int rmode, input bit jitter,
                          input bit probe, input int px, input int py, input int pa, input int pb);
        int acc = 0, cyc, stalls = 0, exp_cnt = 0, exp_ffi = 0;
        bit rdy, seen = 0;
        logic [31:0] ea, eb;
        logic [7:0]  snap;
        b2.op = op; b2.fault_en = fen; b2.fault_idx = fidx; b2.start = 1'b1;
        step();
        b2.start = 1'b0;
        rdy = 1'b1;
        for (cyc = 1; cyc < 200 && !b2.done; cyc++) begin
            if (!rdy) chk("stall_hold", {b2.vec_x, b2.vec_y, b2.res_a, b2.res_b}, snap);
            chk("vec_valid", b2.vec_valid, 1);
            chk("vec_x", b2.vec_x, acc >> 2);
            chk("vec_y", b2.vec_y, acc & 3);
            eb = ref_gate(op, acc >> 2, acc & 3, 2);
            ea = eb ^ ((fen && acc == int'(fidx)) ? 32'd1 : 32'd0);
            chk("res_b", b2.res_b, eb);
            chk("res_a", b2.res_a, ea);
            if (probe && !seen && (acc >> 2) == px && (acc & 3) == py) begin
                seen = 1'b1;
                chk("probe_res_a", b2.res_a, pa);
                chk("probe_res_b", b2.res_b, pb);
            end
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc - 1) % 4 == 0) || ((cyc - 1) % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (jitter) begin
                b2.op = 2'($urandom); b2.fault_en = 1'($urandom);
                b2.fault_idx = 4'($urandom); b2.start = 1'($urandom);
            end
            b2.vec_ready = rdy;
            snap = {b2.vec_x, b2.vec_y, b2.res_a, b2.res_b};
            if (rdy) begin
                if (ea != eb) begin
                    if (exp_cnt == 0) exp_ffi = acc;
                    exp_cnt++;
                end
                acc++;
            end else begin
                stalls++;
            end
            step();
        end
        b2.start = 1'b0;
        b2.vec_ready = 1'b0;
        if (probe) chk("probe_seen", seen, 1);
        chk("done_seen", b2.done, 1);
        chk("done_cycle", cyc, 17 + stalls);
        chk("accepts", acc, 16);
        chk("mismatch_cnt", b2.mismatch_cnt, exp_cnt);
        chk("first_fail_valid", b2.first_fail_valid, exp_cnt != 0);
        chk("first_fail_idx", b2.first_fail_idx, exp_ffi);
        chk("pass", b2.pass, exp_cnt == 0);
        chk("valid_in_done", b2.vec_valid, 0);
        step();
        chk("done_one_cycle", b2.done, 0);
        chk("pass_held", b2.pass, exp_cnt == 0);
        chk("idle_after_done", b2.vec_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [8];
        int acc, cyc;
        tbl = '{
            '{2'd0, 1'b0, 4'd0,  1, 2, 2, 2},
            '{2'd0, 1'b1, 4'd5,  1, 1, 2, 3},
            '{2'd1, 1'b0, 4'd0,  1, 2, 1, 1},
            '{2'd2, 1'b0, 4'd0,  3, 1, 2, 2},
            '{2'd3, 1'b0, 4'd0,  0, 0, 3, 3},
            '{2'd3, 1'b0, 4'd0,  1, 2, 0, 0},
            '{2'd1, 1'b1, 4'd14, 3, 2, 2, 3},
            '{2'd2, 1'b1, 4'd15, 3, 3, 1, 0}
        };
        rst_n = 1'b0;
        b2.start = 0; b2.abort = 0; b2.op = 0; b2.fault_en = 0; b2.fault_idx = 0; b2.vec_ready = 0;
        b3.start = 0; b3.abort = 0; b3.op = 0; b3.fault_en = 0; b3.fault_idx = 0; b3.vec_ready = 0;
        #2;
        chk("rst_vec_valid", b2.vec_valid, 0);
        chk("rst_res_a", b2.res_a, 0);
        chk("rst_res_b", b2.res_b, 0);
        chk("rst_cnt", b2.mismatch_cnt, 0);
        chk("rst_done_pass", {b2.done, b2.pass, b2.first_fail_valid}, 0);
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++)
            sweep2(tbl[i].op, tbl[i].fen, tbl[i].fidx, 0, 1'b0, 1'b1,
                   tbl[i].x, tbl[i].y, tbl[i].a, tbl[i].b);

        // op=2 under a 1,0,0,1 ready pattern with config scrambled mid-run
        sweep2(2'd2, 1'b0, 4'd0, 1, 1'b1, 1'b1, 3, 1, 2, 2);

        for (int i = 0; i < 6; i++)
            sweep2(2'($urandom), 1'($urandom), 4'($urandom), 2, 1'($urandom), 1'b0, 0, 0, 0, 0);

        // abort at idx 7 with fault at idx 3
        b2.op = 0; b2.fault_en = 1; b2.fault_idx = 3; b2.vec_ready = 1; b2.start = 1;
        step();
        b2.start = 0;
        repeat (7) step();
        chk("abort_pre_idx", {b2.vec_x, b2.vec_y}, 7);
        b2.abort = 1;
        step();
        b2.abort = 0;
        b2.vec_ready = 0;
        chk("abort_idle", b2.vec_valid, 0);
        chk("abort_no_done", b2.done, 0);
        chk("abort_cnt", b2.mismatch_cnt, 1);
        chk("abort_ffi", b2.first_fail_idx, 3);
        chk("abort_ffv", b2.first_fail_valid, 1);
        chk("abort_pass", b2.pass, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_later_no_done", b2.done, 0);
        end
        b2.start = 1; b2.abort = 1;
        step();
        b2.start = 0; b2.abort = 0;
        chk("start_abort_idle", b2.vec_valid, 0);
        chk("start_abort_cnt_kept", b2.mismatch_cnt, 1);
        step();
        chk("start_abort_still_idle", b2.vec_valid, 0);

        // asynchronous reset in the middle of a sweep
        b2.op = 1; b2.fault_en = 1; b2.fault_idx = 1; b2.vec_ready = 1; b2.start = 1;
        step();
        b2.start = 0;
        repeat (4) step();
        chk("pre_reset_cnt", b2.mismatch_cnt, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", b2.vec_valid, 0);
        chk("mid_rst_vec", {b2.vec_x, b2.vec_y}, 0);
        chk("mid_rst_res", {b2.res_a, b2.res_b}, 0);
        chk("mid_rst_cnt", b2.mismatch_cnt, 0);
        chk("mid_rst_ff", {b2.first_fail_valid, b2.first_fail_idx}, 0);
        chk("mid_rst_done_pass", {b2.done, b2.pass}, 0);
        b2.vec_ready = 0;
        step();
        chk("in_rst_no_done", b2.done, 0);
        rst_n = 1'b1;
        step();
        sweep2(2'd0, 1'b0, 4'd0, 0, 1'b0, 1'b0, 0, 0, 0, 0);

        // WIDTH=3, op=3, no fault
        b3.op = 3; b3.vec_ready = 1; b3.start = 1;
        step();
        b3.start = 0;
        acc = 0;
        for (cyc = 1; cyc < 200 && !b3.done; cyc++) begin
            chk("w3_vec", {b3.vec_x, b3.vec_y}, acc);
            chk("w3_res_b", b3.res_b, ref_gate(2'd3, acc >> 3, acc & 7, 3));
            chk("w3_res_a", b3.res_a, ref_gate(2'd3, acc >> 3, acc & 7, 3));
            acc++;
            step();
        end
        chk("w3_done_seen", b3.done, 1);
        chk("w3_done_cycle", cyc, 65);
        chk("w3_accepts", acc, 64);
        chk("w3_cnt", b3.mismatch_cnt, 0);
        chk("w3_pass", b3.pass, 1);
        b3.vec_ready = 0;
        step();
        chk("w3_done_one_cycle", b3.done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
